// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: N_CH independent trigger channels. Each channel synchronises
// its asynchronous trigger, detects the edge selected by the shared mode input,
// emits a registered pulse of programmable length and then holds off for a
// programmable number of cycles before accepting another trigger.
// Optional build macro: MULTI_PULSE_RETRIGGER_EN -- when defined, a qualifying
// edge during the pulse restarts the pulse count (pulse stays high, extended).
module multi_pulse_gen #(
  parameter int N_CH        = 4,
  parameter int LEN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  trig,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] pulse_len,
  input  logic [LEN_W-1:0] holdoff,
  output logic [N_CH-1:0]  pulse,
  output logic [N_CH-1:0]  busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Shared reload values: a zero pulse length behaves as one cycle.
  logic [LEN_W-1:0] w_len_m1;
  logic [LEN_W-1:0] w_hold_m1;
  assign w_len_m1  = (pulse_len == '0) ? '0 : (pulse_len - LEN_W'(1));
  assign w_hold_m1 = holdoff - LEN_W'(1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_W-1:0]       r_cnt;
    logic [LEN_W-1:0]       w_cnt_nxt;
    logic                   r_pulse;
    logic                   w_pulse_nxt;
    logic                   r_busy;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;

    // Synchroniser chain plus edge-history flop; prev tracks s even when disabled
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_sync <= '0;
        r_prev <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], trig[g]};
        r_prev <= w_s;
      end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;
    assign w_fall = ~w_s & r_prev;

    // Qualifying edge selected by the shared mode input
    always_comb begin
      w_edge = 1'b0;
      case (mode)
        2'b00:   w_edge = w_rise;
        2'b01:   w_edge = w_fall;
        2'b10:   w_edge = w_rise | w_fall;
        default: w_edge = 1'b0;
      endcase
    end

    // Next-state, counter and pulse logic for the channel FSM
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = r_pulse;
      case (r_state)
        ST_IDLE: begin
          w_pulse_nxt = 1'b0;
          if (w_edge) begin
            w_state_nxt = ST_PULSE;
            w_cnt_nxt   = w_len_m1;
            w_pulse_nxt = 1'b1;
          end
        end
        ST_PULSE: begin
          w_pulse_nxt = 1'b1;
`ifdef MULTI_PULSE_RETRIGGER_EN
          if (w_edge) begin
            w_cnt_nxt = w_len_m1;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end else if (holdoff == '0) begin
            w_state_nxt = ST_IDLE;
            w_pulse_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_HOLDOFF;
            w_pulse_nxt = 1'b0;
            w_cnt_nxt   = w_hold_m1;
          end
`else
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end else if (holdoff == '0) begin
            w_state_nxt = ST_IDLE;
            w_pulse_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_HOLDOFF;
            w_pulse_nxt = 1'b0;
            w_cnt_nxt   = w_hold_m1;
          end
`endif
        end
        ST_HOLDOFF: begin
          w_pulse_nxt = 1'b0;
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b0;
        end
      endcase
    end

    // State, counter and registered outputs; busy follows the next state
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pulse <= w_pulse_nxt;
        r_busy  <= (w_state_nxt != ST_IDLE);
      end
    end

    assign pulse[g] = r_pulse;
    assign busy[g]  = r_busy;
  end : g_ch

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: directed bench for multi_pulse_gen with an expectation
// queue. Expected values are queued as each step is driven and popped as the
// measured DUT behaviour becomes available.
module tb_multi_pulse_gen;
  localparam int N_CH  = 4;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N_CH-1:0]  trig;
  logic [1:0]       mode;
  logic [LEN_W-1:0] pulse_len;
  logic [LEN_W-1:0] holdoff;
  logic [N_CH-1:0]  pulse;
  logic [N_CH-1:0]  busy;

  multi_pulse_gen #(.N_CH(N_CH), .LEN_W(LEN_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .trig      (trig),
    .mode      (mode),
    .pulse_len (pulse_len),
    .holdoff   (holdoff),
    .pulse     (pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    exp_q[$];
  string tag_q[$];

  // per-channel measurements from the last observation window
  int pc[N_CH];  // cycles with pulse high
  int bc[N_CH];  // cycles with busy high
  int rc[N_CH];  // number of pulse rises
  int fc[N_CH];  // sample index of first pulse-high cycle (-1 if none)

  task automatic expect_val(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input int obs);
    string t;
    int    e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %0d want nothing queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: got %0d want %0d", t, obs, e);
      end
    end
  endtask

  // Observe n cycles, sampling on the falling edge
  task automatic window(input int n);
    logic [N_CH-1:0] last;
    for (int c = 0; c < N_CH; c++) begin
      pc[c] = 0; bc[c] = 0; rc[c] = 0; fc[c] = -1;
    end
    last = pulse;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) begin
        if (pulse[c] === 1'b1) begin
          pc[c]++;
          if (last[c] !== 1'b1) rc[c]++;
          if (fc[c] < 0) fc[c] = k;
        end
        if (busy[c] === 1'b1) bc[c]++;
      end
      last = pulse;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    trig      = '0;
    mode      = 2'b00;
    pulse_len = 16'd1;
    holdoff   = 16'd0;

    // 1: reset holds outputs low while triggers toggle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      trig = ~trig;
      if (k == 2 || k == 5) begin
        expect_val("rst_pulse", 0); check(int'(pulse));
        expect_val("rst_busy", 0);  check(int'(busy));
      end
    end
    trig = '0;
    @(negedge clk);
    resetn = 1'b1;
    window(8);
    for (int c = 0; c < N_CH; c++) begin
      expect_val($sformatf("rel_pc%0d", c), 0); check(pc[c]);
    end

    // 2: exact latency of a single-cycle pulse on channel 0
    @(negedge clk);
    trig[0] = 1'b1;
    @(negedge clk); expect_val("lat_e0", 0); check(int'(pulse));
    @(negedge clk); expect_val("lat_e1", 0); check(int'(pulse));
    @(negedge clk); expect_val("lat_e2_pulse", 1); check(int'(pulse));
                    expect_val("lat_e2_busy", 1);  check(int'(busy));
    @(negedge clk); expect_val("lat_e3_pulse", 0); check(int'(pulse));
                    expect_val("lat_e3_busy", 0);  check(int'(busy));
    idle(3);
    trig[0] = 1'b0;
    window(8);
    expect_val("rise_mode_fall_ign", 0); check(pc[0]);
    // falling-edge mode
    mode = 2'b01; pulse_len = 16'd3;
    trig[0] = 1'b1;
    window(8);
    expect_val("fall_mode_rise_ign", 0); check(pc[0]);
    trig[0] = 1'b0;
    window(8);
    expect_val("fall_mode_len", 3); check(pc[0]);
    expect_val("fall_mode_fc", 2);  check(fc[0]);

    // 3: both-edge mode, length 5, holdoff 3
    mode = 2'b10; pulse_len = 16'd5; holdoff = 16'd3;
    trig[1] = 1'b1;
    window(20);
    expect_val("both_rise_pc", 5); check(pc[1]);
    expect_val("both_rise_bc", 8); check(bc[1]);
    expect_val("both_rise_rc", 1); check(rc[1]);
    expect_val("both_other_ch", 0); check(pc[0]);
    trig[1] = 1'b0;
    window(20);
    expect_val("both_fall_pc", 5); check(pc[1]);
    expect_val("both_fall_bc", 8); check(bc[1]);
    pulse_len = 16'd0;
    trig[1] = 1'b1;
    window(10);
    expect_val("len0_pc", 1); check(pc[1]);
    expect_val("len0_bc", 4); check(bc[1]);

    // 4: second edge inside the pulse, edge inside holdoff
    mode = 2'b00; pulse_len = 16'd10; holdoff = 16'd4;
    idle(3);
`ifdef MULTI_PULSE_RETRIGGER_EN
    expect_val("retrig_pc", 16); expect_val("retrig_bc", 20);
`else
    expect_val("retrig_pc", 10); expect_val("retrig_bc", 14);
`endif
    expect_val("retrig_rc", 1);
    trig[2] = 1'b1;
    fork
      window(40);
      begin
        idle(3); trig[2] = 1'b0;
        idle(3); trig[2] = 1'b1;
      end
    join
    check(pc[2]); check(bc[2]); check(rc[2]);

    trig[2] = 1'b0;
    idle(5);
    expect_val("hold_ign_pc", 10); expect_val("hold_ign_bc", 14); expect_val("hold_ign_rc", 1);
    trig[2] = 1'b1;
    fork
      window(30);
      begin
        idle(5);  trig[2] = 1'b0;
        idle(6);  trig[2] = 1'b1;
      end
    join
    check(pc[2]); check(bc[2]); check(rc[2]);

    trig[2] = 1'b0;
    idle(5);
    expect_val("post_hold_pc", 20); expect_val("post_hold_bc", 28); expect_val("post_hold_rc", 2);
    trig[2] = 1'b1;
    fork
      window(50);
      begin
        idle(5);  trig[2] = 1'b0;
        idle(10); trig[2] = 1'b1;
      end
    join
    check(pc[2]); check(bc[2]); check(rc[2]);

    // 5: disable mid-pulse, stale level, simultaneous channels
    pulse_len = 16'd8; holdoff = 16'd2;
    trig[3] = 1'b1;
    fork
      window(20);
      begin
        idle(4); mode = 2'b11;
      end
    join
    expect_val("dis_complete_pc", 8);  check(pc[3]);
    expect_val("dis_complete_bc", 10); check(bc[3]);
    trig[3] = 1'b0;
    idle(3);
    trig[3] = 1'b1;
    window(10);
    expect_val("dis_no_trig", 0); check(pc[3]);
    mode = 2'b00;
    window(10);
    expect_val("reen_stale", 0); check(pc[3]);
    trig = '0;
    window(5);
    trig = '1;
    window(20);
    for (int c = 0; c < N_CH; c++) begin
      expect_val($sformatf("all_pc%0d", c), 8);  check(pc[c]);
      expect_val($sformatf("all_bc%0d", c), 10); check(bc[c]);
      expect_val($sformatf("all_fc%0d", c), 2);  check(fc[c]);
    end

    // 6: asynchronous reset during a pulse
    trig = '0;
    pulse_len = 16'd10; holdoff = 16'd0;
    idle(4);
    trig[0] = 1'b1;
    idle(5);
    expect_val("pre_rst_pulse", 1); check(int'(pulse[0]));
    #2 resetn = 1'b0;
    #1;
    expect_val("async_rst_pulse", 0); check(int'(pulse));
    expect_val("async_rst_busy", 0);  check(int'(busy));
    @(negedge clk);
    trig = '0;
    @(negedge clk);
    resetn = 1'b1;
    window(4);
    expect_val("after_rst_idle", 0); check(bc[0]);
    trig[0] = 1'b1;
    window(20);
    expect_val("after_rst_pc", 10); check(pc[0]);
    expect_val("after_rst_bc", 10); check(bc[0]);
    expect_val("after_rst_fc", 2);  check(fc[0]);
    // trigger held high through reset release produces one pulse
    trig[1] = 1'b1;
    idle(16);
    @(negedge clk);
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    window(20);
    expect_val("held_pc0", 10); check(pc[0]);
    expect_val("held_rc0", 1);  check(rc[0]);
    expect_val("held_pc1", 10); check(pc[1]);
    expect_val("held_fc1", 2);  check(fc[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
